// File: rtl/poly_coef_loader.sv
// Load front-end for the polynomial evaluator: streams x then c0..cn into a
// coefficient bank, exposes them to the evaluator and holds start_eval until done.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for cmd_start; bank, x_out, n_out retained
// LOAD_X    | in_ready high, next accepted word is the evaluation point
// LOAD_COEF | in_ready high, accepted words fill coef[0..n_out]
// ARMED     | start_eval held high until eval_done
module poly_coef_loader #(
    parameter int COEF_W    = 16,
    parameter int MAX_TERMS = 8,
    parameter int N_W       = 4,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [N_W-1:0]    cfg_n,
    input  logic              in_valid,
    input  logic [COEF_W-1:0] in_data,
    output logic              in_ready,
    output logic [COEF_W-1:0] x_out,
    output logic [N_W-1:0]    n_out,
    input  logic [IDX_W-1:0]  coef_rd_idx,
    output logic [COEF_W-1:0] coef_rd_data,
    output logic              start_eval,
    input  logic              eval_done,
    output logic              busy,
    output logic              load_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_X    = 2'd1,
        LOAD_COEF = 2'd2,
        ARMED     = 2'd3
    } state_t;

    localparam logic [N_W-1:0] MAX_N = N_W'(MAX_TERMS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [COEF_W-1:0] bank [MAX_TERMS];
    logic [IDX_W-1:0]  widx;
    logic              xfer;
    logic              start_req;
    logic              start_ok;
    logic              last_coef;

    assign xfer      = in_valid && in_ready;
    // abort wins over a simultaneous start, so a start with abort does nothing
    assign start_req = cmd_start && !cmd_abort;
    assign start_ok  = start_req && (cfg_n <= MAX_N);
    assign last_coef = (N_W'(widx) == n_out);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok)
                    state_nxt = LOAD_X;
            end
            LOAD_X: begin
                if (cmd_abort)
                    state_nxt = IDLE;
                else if (xfer)
                    state_nxt = LOAD_COEF;
            end
            LOAD_COEF: begin
                if (cmd_abort)
                    state_nxt = IDLE;
                else if (xfer && last_coef)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (cmd_abort || eval_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            widx       <= '0;
            x_out      <= '0;
            n_out      <= '0;
            in_ready   <= 1'b0;
            start_eval <= 1'b0;
            busy       <= 1'b0;
            load_err   <= 1'b0;
            for (int i = 0; i < MAX_TERMS; i++)
                bank[i] <= '0;
        end else begin
            state      <= state_nxt;
            in_ready   <= (state_nxt == LOAD_X) || (state_nxt == LOAD_COEF);
            start_eval <= (state_nxt == ARMED);
            busy       <= (state_nxt != IDLE);

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        n_out    <= cfg_n;
                        load_err <= 1'b0;
                        widx     <= '0;
                        // clearing the bank makes entries above n_out read as zero
                        for (int i = 0; i < MAX_TERMS; i++)
                            bank[i] <= '0;
                    end else if (start_req) begin
                        load_err <= 1'b1;
                    end
                end
                LOAD_X: begin
                    if (!cmd_abort && xfer)
                        x_out <= in_data;
                end
                LOAD_COEF: begin
                    if (!cmd_abort && xfer) begin
                        bank[widx] <= in_data;
                        if (!last_coef)
                            widx <= widx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign coef_rd_data = bank[coef_rd_idx];

endmodule
